servo_pwm_decoder: RTL and testbench
====================================

SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

Interface
REQ-001 Parameter MIN_PW, default 25000, pulse width in clk cycles mapped to position 0 (1 ms at 25 MHz).
REQ-002 Parameter MAX_PW, default 50000, longest legal pulse width in clk cycles (2 ms).
REQ-003 Parameter STEP, default 98, clk cycles per position LSB above MIN_PW.
REQ-004 Parameter TIMEOUT, default 600000, maximum cycles between rising edges (24 ms).
REQ-005 clk  input  1  system clock, 25 MHz, rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 pwm_in  input  1  servo PWM line, asynchronous to clk.
REQ-008 position  output  8  decoded position code, held between updates.
REQ-009 pulse_width  output  20  last measured high time in clk cycles.
REQ-010 valid  output  1  one-cycle strobe when position and pulse_width update.
REQ-011 err_range  output  1  one-cycle strobe when a pulse is outside MIN_PW/2..MAX_PW+MIN_PW/2.
REQ-012 timeout  output  1  level; no rising edge seen for TIMEOUT cycles.
REQ-013 locked  output  1  level; last pulse was valid and no timeout since.

Function
REQ-014 pwm_in shall pass through a 2-FF synchronizer; all edge detection uses the synchronized signal (sync_in).
REQ-015 FSM states: ARM (wait for sync_in low), WAIT_RISE, HIGH, DONE.
REQ-016 ARM -> WAIT_RISE when sync_in is 0, so a pulse already high after reset is never measured.
REQ-017 WAIT_RISE -> HIGH on rising edge of sync_in; width counter loads 1; period counter clears.
REQ-018 In HIGH the width counter increments once per cycle sync_in is 1, saturating at 2^20-1.
REQ-019 In HIGH, once width exceeds MIN_PW, a prescaler counts STEP cycles and increments a position accumulator, saturating at 255.
REQ-020 HIGH -> DONE on falling edge; DONE lasts exactly one cycle, then -> WAIT_RISE.
REQ-021 In DONE, if MIN_PW/2 <= width <= MAX_PW+MIN_PW/2: position and pulse_width load, valid=1, locked=1.
REQ-022 In DONE, if width is outside that window: position/pulse_width unchanged, err_range=1, locked=0.
REQ-023 Widths in MIN_PW/2..MIN_PW-1 shall decode to position 0; widths in MAX_PW..MAX_PW+MIN_PW/2 to 255.
REQ-024 valid and err_range shall never be high in the same cycle.
REQ-025 Period counter runs in every state except ARM, clears on each rising edge, saturates at TIMEOUT.
REQ-026 Period counter reaching TIMEOUT sets timeout=1 and locked=0 and forces the FSM to WAIT_RISE; a pulse still in progress is discarded.
REQ-027 timeout clears on the next rising edge of sync_in.
REQ-028 Latency: valid asserts 3 clk cycles after pwm_in falls (2 synchronizer stages plus DONE), 3+FILT_LEN with the filter.

Reset
REQ-029 rst_n low shall asynchronously force: FSM=ARM, all counters 0, position=0, pulse_width=0, valid=0, err_range=0, timeout=0, locked=0, synchronizer and filter flops 0.
REQ-030 Reset mid-pulse discards the pulse; the next complete pulse after ARM is the first one measured.

Configuration
REQ-031 Macro SERVO_DEC_FILTER_EN defined: a glitch filter after the synchronizer passes a new level only after 4 consecutive identical samples (FILT_LEN=4); shorter glitches are ignored.
REQ-032 Macro SERVO_DEC_FILTER_EN undefined: no filter; sync_in drives the FSM directly, and all other behaviour is identical.

Verification
REQ-033 Reset, then 37500-cycle high pulse in a 500000-cycle period -> valid strobe once, position=127, pulse_width=37500, locked=1.
REQ-034 25000-cycle pulse -> position=0; 50000-cycle pulse -> position=255; 55000-cycle pulse -> position=255, valid=1.
REQ-035 10000-cycle pulse -> err_range strobe, valid=0, position unchanged, locked=0.
REQ-036 pwm_in held low for 600000 cycles after a valid pulse -> timeout=1, locked=0; next rising edge -> timeout=0.
REQ-037 Release reset while pwm_in is high for 30000 cycles -> no valid or err_range strobe; the following 37500-cycle pulse gives position=127.
REQ-038 With SERVO_DEC_FILTER_EN: a 2-cycle low glitch inside a 37500-cycle pulse -> one valid strobe, pulse_width=37500. Without the filter: err_range or two pulses.

Source files
------------

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures the high time of a hobby-servo pulse and maps it to an 8-bit position.
// Optional glitch filter on the synchronized input is enabled by defining SERVO_DEC_FILTER_EN.
module servo_pwm_decoder #(
  parameter int unsigned MIN_PW  = 25000,
  parameter int unsigned MAX_PW  = 50000,
  parameter int unsigned STEP    = 98,
  parameter int unsigned TIMEOUT = 600000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [7:0]  position,
  output logic [19:0] pulse_width,
  output logic        valid,
  output logic        err_range,
  output logic        timeout,
  output logic        locked
);

  localparam int PW = $clog2(TIMEOUT + 1);
  localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [19:0]   MIN_W  = 20'(MIN_PW);
  localparam logic [19:0]   MAX_W  = 20'(MAX_PW);
  localparam logic [19:0]   WIN_LO = 20'(MIN_PW / 2);
  localparam logic [19:0]   WIN_HI = 20'(MAX_PW + MIN_PW / 2);
  localparam logic [PW-1:0] TO_MAX = PW'(TIMEOUT);
  localparam logic [PW-1:0] TO_PRE = PW'(TIMEOUT - 1);
  localparam logic [SW-1:0] PS_END = SW'(STEP - 1);

  typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH, DONE} state_t;

  state_t        state;
  logic [1:0]    sync_ff;
  logic          sync_in;
  logic          lvl;
  logic          lvl_q;
  logic          rise;
  logic          to_hit;
  logic [19:0]   width;
  logic [PW-1:0] period;
  logic [SW-1:0] presc;
  logic [7:0]    acc;
  logic [3:0]    arm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= '0;
    else        sync_ff <= {sync_ff[0], pwm_in};
  end
  assign sync_in = sync_ff[1];

`ifdef SERVO_DEC_FILTER_EN
  // Level changes only after four identical samples (three held plus the current one).
  logic [2:0] filt_hist;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_hist <= '0;
      lvl       <= 1'b0;
    end else begin
      filt_hist <= {filt_hist[1:0], sync_in};
      if (sync_in && (&filt_hist))        lvl <= 1'b1;
      else if (!sync_in && !(|filt_hist)) lvl <= 1'b0;
    end
  end
`else
  assign lvl = sync_in;
`endif

  assign rise   = lvl && !lvl_q;
  assign to_hit = (state != ARM) && !rise && (period == TO_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARM;
      lvl_q       <= 1'b0;
      width       <= '0;
      period      <= '0;
      presc       <= '0;
      acc         <= '0;
      arm_cnt     <= '0;
      position    <= '0;
      pulse_width <= '0;
      valid       <= 1'b0;
      err_range   <= 1'b0;
      timeout     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      lvl_q     <= lvl;
      valid     <= 1'b0;
      err_range <= 1'b0;
      if (state == ARM) begin
        // Synchronizer/filter flops come out of reset low; let them fill with the
        // real line level first, or a pulse already high would look like a fresh rise.
        period <= '0;
        if (arm_cnt != '1) arm_cnt <= arm_cnt + 4'd1;
        else if (!lvl)     state   <= WAIT_RISE;
      end else begin
        if (rise) begin
          period  <= '0;
          timeout <= 1'b0;
        end else if (period != TO_MAX) begin
          period <= period + PW'(1);
        end

        if (to_hit) begin
          timeout <= 1'b1;
          locked  <= 1'b0;
          state   <= WAIT_RISE;
        end else begin
          case (state)
            WAIT_RISE: if (rise) begin
              state <= HIGH;
              width <= 20'd1;
              presc <= '0;
              acc   <= '0;
            end
            HIGH: if (lvl) begin
              if (width != '1) width <= width + 20'd1;
              if (width >= MIN_W) begin
                if (presc == PS_END) begin
                  presc <= '0;
                  if (acc != 8'hff) acc <= acc + 8'd1;
                end else begin
                  presc <= presc + SW'(1);
                end
              end
            end else begin
              state <= DONE;
              if (width >= WIN_LO && width <= WIN_HI) begin
                valid       <= 1'b1;
                locked      <= 1'b1;
                pulse_width <= width;
                // Over-long pulses pin to full scale regardless of STEP rounding.
                position    <= (width >= MAX_W) ? 8'hff : acc;
              end else begin
                err_range <= 1'b1;
                locked    <= 1'b0;
              end
            end
            DONE:    state <= WAIT_RISE;
            default: state <= ARM;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder using scaled-down timing parameters.
module tb_servo_pwm_decoder;

  localparam int MIN_PW  = 512;
  localparam int MAX_PW  = 1024;
  localparam int STEP    = 2;
  localparam int TIMEOUT = 5000;
  localparam int PERIOD  = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [7:0]  position;
  logic [19:0] pulse_width;
  logic        valid, err_range, timeout, locked;

  servo_pwm_decoder #(.MIN_PW(MIN_PW), .MAX_PW(MAX_PW), .STEP(STEP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .position(position), .pulse_width(pulse_width),
    .valid(valid), .err_range(err_range), .timeout(timeout), .locked(locked)
  );

  always #20 clk = ~clk;

  typedef enum int {EV_VALID, EV_ERR, EV_TO, EV_TOCLR} ev_t;
  typedef struct {ev_t kind; int pos; int pw;} exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input ev_t k, input int p, input int w);
    exp_t e;
    e.kind = k; e.pos = p; e.pw = w;
    return e;
  endfunction

  task automatic pulse(input int hi, input int lo);
    pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Monitor: every strobe and every timeout transition consumes one expectation.
  logic to_q = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      to_q = 1'b0;
    end else begin
      if (valid || err_range) begin
        chk("strobe_exclusive", 32'(valid && err_range), 32'd0);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: valid=%0d err_range=%0d, expected none", valid, err_range);
        end else begin
          e = q.pop_front();
          chk("event_kind", valid ? EV_VALID : EV_ERR, e.kind);
          chk("position", 32'(position), e.pos);
          chk("pulse_width", 32'(pulse_width), e.pw);
          chk("locked", 32'(locked), (e.kind == EV_VALID) ? 32'd1 : 32'd0);
        end
      end
      if (timeout != to_q) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_timeout_edge: timeout=%0d, expected no change", timeout);
        end else begin
          e = q.pop_front();
          chk("timeout_edge", timeout ? EV_TO : EV_TOCLR, e.kind);
          if (timeout) chk("locked_on_timeout", 32'(locked), 32'd0);
        end
      end
      to_q = timeout;
    end
  end

  // Hand-computed vectors: position = floor((w-512)/2) clamped, window 256..1280.
  int tw[12]  = '{768, 512, 1024, 1100, 200, 256, 255, 1280, 1281, 600, 514, 513};
  int tk[12]  = '{0,   0,   0,    0,    1,   0,   1,   0,    1,    0,   0,   0};
  int tp[12]  = '{128, 0,   255,  255,  255, 0,   0,   255,  255,  44,  1,   0};
  int tpw[12] = '{768, 512, 1024, 1100, 1100, 256, 256, 1280, 1280, 600, 514, 513};

  initial begin
    rst_n = 1'b0; pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_position", 32'(position), 32'd0);
    chk("rst_pulse_width", 32'(pulse_width), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err_range", 32'(err_range), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      q.push_back(mk(tk[i] ? EV_ERR : EV_VALID, tp[i], tpw[i]));
      pulse(tw[i], PERIOD - tw[i]);
    end

    // Line idle long enough to time out, then a pulse recovers lock.
    q.push_back(mk(EV_TO, 0, 0));
    repeat (TIMEOUT) @(negedge clk);
    chk("timeout_level", 32'(timeout), 32'd1);
    chk("locked_after_timeout", 32'(locked), 32'd0);
    q.push_back(mk(EV_TOCLR, 0, 0));
    q.push_back(mk(EV_VALID, 128, 768));
    pulse(768, PERIOD - 768);
    chk("timeout_cleared", 32'(timeout), 32'd0);

    // Reset in the middle of a high pulse; the tail must not be measured.
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    pwm_in = 1'b0;
    repeat (1000) @(negedge clk);
    chk("no_lock_after_reset_pulse", 32'(locked), 32'd0);
    q.push_back(mk(EV_VALID, 128, 768));
    pulse(768, PERIOD - 768);

    // Two-cycle low glitch inside a 768-cycle pulse.
`ifdef SERVO_DEC_FILTER_EN
    q.push_back(mk(EV_VALID, 128, 768));
`else
    q.push_back(mk(EV_VALID, 0, 400));
    q.push_back(mk(EV_VALID, 0, 366));
`endif
    pwm_in = 1'b1;
    repeat (400) @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    pulse(366, PERIOD);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
